// File: rtl/branch_tag_allocator.sv
// Branch checkpoint tag allocator: hands out up to two RAT checkpoint tags per
// cycle, retires them in program order on resolve and clears all of them on flush.
module branch_tag_allocator #(
  parameter int PC_BITS       = 32,
  parameter int MAX_BRANCH_IF = 2,
  parameter int ID_BITS       = $clog2(MAX_BRANCH_IF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc_req_1,
  input  logic               alloc_req_2,
  input  logic [PC_BITS-1:0] alloc_pc_1,
  input  logic [PC_BITS-1:0] alloc_pc_2,
  output logic               alloc_grant,
  output logic [ID_BITS-1:0] alloc_id_1,
  output logic [ID_BITS-1:0] alloc_id_2,
  output logic               branch_stall,
  input  logic               resolve_valid,
  input  logic [ID_BITS-1:0] resolve_id,
  input  logic               flush,
  output logic               head_valid,
  output logic [ID_BITS-1:0] head_id,
  output logic [PC_BITS-1:0] head_pc,
  output logic [ID_BITS:0]   in_flight,
  output logic               one_free,
  output logic               two_free,
  output logic               order_err
);

  localparam logic [ID_BITS:0] MAX_CNT = (ID_BITS+1)'(MAX_BRANCH_IF);
  localparam logic [ID_BITS:0] MAX_M2  = (ID_BITS+1)'(MAX_BRANCH_IF - 2);

  logic [ID_BITS-1:0] head_q, head_d;
  logic [ID_BITS-1:0] tail_q, tail_d;
  logic [ID_BITS:0]   count_q, count_d;
  logic               order_err_q, order_err_d;
  logic [PC_BITS-1:0] pc_mem [MAX_BRANCH_IF];

  logic               resolve_ok;
  logic               resolve_bad;
  logic [ID_BITS:0]   grant_n;

  // Stall and grant depend only on registered occupancy, never on resolve.
  assign one_free     = count_q < MAX_CNT;
  assign two_free     = count_q <= MAX_M2;
  assign branch_stall = (alloc_req_1 & ~alloc_req_2 & ~one_free) |
                        (alloc_req_1 &  alloc_req_2 & ~two_free);
  assign alloc_grant  = alloc_req_1 & ~branch_stall & ~flush;
  assign alloc_id_1   = tail_q;
  assign alloc_id_2   = tail_q + ID_BITS'(1);

  assign resolve_ok  = resolve_valid & ~flush & (count_q != '0) & (resolve_id == head_q);
  assign resolve_bad = resolve_valid & ~flush & ~resolve_ok;

  always_comb begin
    grant_n = '0;
    if (alloc_grant) grant_n = alloc_req_2 ? (ID_BITS+1)'(2) : (ID_BITS+1)'(1);
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    order_err_d = order_err_q;
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      order_err_d = 1'b0;
    end else begin
      tail_d  = tail_q + grant_n[ID_BITS-1:0];
      count_d = count_q + grant_n - {{ID_BITS{1'b0}}, resolve_ok};
      if (resolve_ok)  head_d      = head_q + ID_BITS'(1);
      if (resolve_bad) order_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      order_err_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      order_err_q <= order_err_d;
    end
  end

  // PC storage is deliberately left unreset; it is only observed while head_valid.
  always_ff @(posedge clk) begin
    if (alloc_grant) begin
      pc_mem[tail_q] <= alloc_pc_1;
      if (alloc_req_2) pc_mem[alloc_id_2] <= alloc_pc_2;
    end
  end

  assign head_valid = count_q != '0;
  assign head_id    = head_q;
  assign head_pc    = pc_mem[head_q];
  assign in_flight  = count_q;
  assign order_err  = order_err_q;

endmodule

// File: tb/tb_branch_tag_allocator.sv
// Self-checking bench for branch_tag_allocator: directed vector table, a few
// hand-written corner sequences, then random traffic against a queue model.
module tb_branch_tag_allocator;

  localparam int PCB = 32;
  localparam int MAX = 2;
  localparam int IDB = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           alloc_req_1, alloc_req_2;
  logic [PCB-1:0] alloc_pc_1, alloc_pc_2;
  logic           alloc_grant;
  logic [IDB-1:0] alloc_id_1, alloc_id_2;
  logic           branch_stall;
  logic           resolve_valid;
  logic [IDB-1:0] resolve_id;
  logic           flush;
  logic           head_valid;
  logic [IDB-1:0] head_id;
  logic [PCB-1:0] head_pc;
  logic [IDB:0]   in_flight;
  logic           one_free, two_free, order_err;

  branch_tag_allocator #(.PC_BITS(PCB), .MAX_BRANCH_IF(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req_1(alloc_req_1), .alloc_req_2(alloc_req_2),
    .alloc_pc_1(alloc_pc_1), .alloc_pc_2(alloc_pc_2),
    .alloc_grant(alloc_grant), .alloc_id_1(alloc_id_1), .alloc_id_2(alloc_id_2),
    .branch_stall(branch_stall),
    .resolve_valid(resolve_valid), .resolve_id(resolve_id), .flush(flush),
    .head_valid(head_valid), .head_id(head_id), .head_pc(head_pc),
    .in_flight(in_flight), .one_free(one_free), .two_free(two_free),
    .order_err(order_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: the in-flight branches as an ordered list of PCs.
  logic [PCB-1:0] pcq[$];
  int m_head = 0;
  bit m_err  = 0;

  function automatic int need_tags();
    return alloc_req_1 ? (alloc_req_2 ? 2 : 1) : 0;
  endfunction

  function automatic bit m_stall();
    return need_tags() > (MAX - pcq.size());
  endfunction

  function automatic bit m_grant();
    return alloc_req_1 && !m_stall() && !flush;
  endfunction

  task automatic model_step();
    bit g;
    g = m_grant();
    if (flush) begin
      pcq.delete();
      m_head = 0;
      m_err  = 0;
    end else begin
      if (resolve_valid) begin
        if (pcq.size() == 0 || int'(resolve_id) != m_head) m_err = 1;
        else begin
          void'(pcq.pop_front());
          m_head = (m_head + 1) % MAX;
        end
      end
      if (g) begin
        pcq.push_back(alloc_pc_1);
        if (alloc_req_2) pcq.push_back(alloc_pc_2);
      end
    end
  endtask

  task automatic drive(input bit r1, input bit r2, input logic [PCB-1:0] p1,
                       input logic [PCB-1:0] p2, input bit rv, input int rid, input bit fl);
    alloc_req_1   = r1;
    alloc_req_2   = r2;
    alloc_pc_1    = p1;
    alloc_pc_2    = p2;
    resolve_valid = rv;
    resolve_id    = IDB'(rid);
    flush         = fl;
  endtask

  task automatic clock_it();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    bit r1, r2;
    logic [PCB-1:0] pc1, pc2;
    bit rv;
    int rid;
    bit fl;
    bit e_grant, e_stall;
    int e_id1, e_if, e_head;
    bit e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r1, input bit r2, input logic [PCB-1:0] p1, input logic [PCB-1:0] p2,
                     input bit rv, input int rid, input bit fl,
                     input bit eg, input bit es, input int eid, input int eif, input int eh, input bit ee);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.pc1 = p1; v.pc2 = p2; v.rv = rv; v.rid = rid; v.fl = fl;
    v.e_grant = eg; v.e_stall = es; v.e_id1 = eid; v.e_if = eif; v.e_head = eh; v.e_err = ee;
    vq.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_in_flight", 64'(in_flight), 0);
    chk("rst_head_valid", 64'(head_valid), 0);
    chk("rst_head_id", 64'(head_id), 0);
    chk("rst_one_free", 64'(one_free), 1);
    chk("rst_two_free", 64'(two_free), 1);
    chk("rst_stall", 64'(branch_stall), 0);
    chk("rst_grant", 64'(alloc_grant), 0);
    chk("rst_order_err", 64'(order_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    //   r1 r2 pc1    pc2    rv rid fl | grant stall id1 in_flight head err  (expected before the edge)
    add(0, 0, 0,     0,     0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(1, 0, 'h100, 0,     0, 0, 0,   1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0,     1, 0, 0,   0, 0, 1, 1, 0, 0);
    add(0, 0, 0,     0,     0, 0, 0,   0, 0, 1, 0, 1, 0);
    add(1, 1, 'h200, 'h202, 0, 0, 0,   1, 0, 1, 0, 1, 0);
    add(1, 0, 'h204, 0,     0, 0, 0,   0, 1, 1, 2, 1, 0);
    add(1, 0, 'h204, 0,     1, 1, 0,   0, 1, 1, 2, 1, 0);
    add(1, 0, 'h206, 0,     0, 0, 0,   1, 0, 1, 1, 0, 0);
    add(0, 0, 0,     0,     1, 0, 0,   0, 0, 0, 2, 0, 0);
    add(1, 1, 'h300, 'h302, 0, 0, 0,   0, 1, 0, 1, 1, 0);
    add(1, 0, 'h300, 0,     0, 0, 0,   1, 0, 0, 1, 1, 0);
    add(1, 0, 'h400, 0,     1, 1, 1,   0, 1, 1, 2, 1, 0);
    add(0, 0, 0,     0,     0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0,     1, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0,     0, 0, 0,   0, 0, 0, 0, 0, 1);
    add(0, 0, 0,     0,     0, 0, 1,   0, 0, 0, 0, 0, 1);
    add(0, 0, 0,     0,     0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(1, 0, 'h500, 0,     0, 0, 0,   1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0,     1, 0, 0,   0, 0, 1, 1, 0, 0);
    add(1, 0, 'h510, 0,     0, 0, 0,   1, 0, 1, 0, 1, 0);
    add(0, 0, 0,     0,     1, 0, 0,   0, 0, 0, 1, 1, 0);
    add(0, 0, 0,     0,     0, 0, 0,   0, 0, 0, 1, 1, 1);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].r1, vq[i].r2, vq[i].pc1, vq[i].pc2, vq[i].rv, vq[i].rid, vq[i].fl);
      #2;
      chk($sformatf("v%0d_grant", i), 64'(alloc_grant), 64'(vq[i].e_grant));
      chk($sformatf("v%0d_stall", i), 64'(branch_stall), 64'(vq[i].e_stall));
      chk($sformatf("v%0d_id1", i), 64'(alloc_id_1), 64'(vq[i].e_id1));
      chk($sformatf("v%0d_id2", i), 64'(alloc_id_2), 64'((vq[i].e_id1 + 1) % MAX));
      chk($sformatf("v%0d_in_flight", i), 64'(in_flight), 64'(vq[i].e_if));
      chk($sformatf("v%0d_one_free", i), 64'(one_free), 64'(vq[i].e_if < MAX));
      chk($sformatf("v%0d_two_free", i), 64'(two_free), 64'(vq[i].e_if <= MAX - 2));
      chk($sformatf("v%0d_head_id", i), 64'(head_id), 64'(vq[i].e_head));
      chk($sformatf("v%0d_head_valid", i), 64'(head_valid), 64'(vq[i].e_if != 0));
      chk($sformatf("v%0d_order_err", i), 64'(order_err), 64'(vq[i].e_err));
      $display("vec %0d r1=%0b r2=%0b rv=%0b rid=%0d fl=%0b grant=%0b stall=%0b in_flight=%0d",
               i, vq[i].r1, vq[i].r2, vq[i].rv, vq[i].rid, vq[i].fl, alloc_grant, branch_stall, in_flight);
      clock_it();
    end

    // Stored PCs reach head_pc in order, including a dual allocation.
    drive(0, 0, 0, 0, 0, 0, 1); clock_it();
    drive(1, 1, 'h700, 'h702, 0, 0, 0); clock_it();
    drive(0, 0, 0, 0, 0, 0, 0); #2;
    chk("seq_head_pc_first", 64'(head_pc), 'h700);
    drive(0, 0, 0, 0, 1, 0, 0); clock_it();
    drive(0, 0, 0, 0, 0, 0, 0); #2;
    chk("seq_head_pc_second", 64'(head_pc), 'h702);
    chk("seq_head_id_second", 64'(head_id), 1);
    $display("seq head_pc in_flight=%0d head_pc=%0h", in_flight, head_pc);
    clock_it();

    // Random traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      bit r1, r2, rv, fl;
      int rid;
      r1  = $urandom_range(0, 9) < 6;
      r2  = r1 && ($urandom_range(0, 9) < 4);
      rv  = $urandom_range(0, 9) < 4;
      rid = ($urandom_range(0, 9) < 8) ? m_head : int'($urandom_range(0, MAX - 1));
      fl  = $urandom_range(0, 31) == 0;
      drive(r1, r2, $urandom, $urandom, rv, rid, fl);
      #2;
      chk("rnd_grant", 64'(alloc_grant), 64'(m_grant()));
      chk("rnd_stall", 64'(branch_stall), 64'(m_stall()));
      chk("rnd_id1", 64'(alloc_id_1), 64'((m_head + pcq.size()) % MAX));
      chk("rnd_id2", 64'(alloc_id_2), 64'((m_head + pcq.size() + 1) % MAX));
      chk("rnd_in_flight", 64'(in_flight), 64'(pcq.size()));
      chk("rnd_one_free", 64'(one_free), 64'(pcq.size() < MAX));
      chk("rnd_two_free", 64'(two_free), 64'(pcq.size() + 2 <= MAX));
      chk("rnd_head_valid", 64'(head_valid), 64'(pcq.size() != 0));
      chk("rnd_head_id", 64'(head_id), 64'(m_head));
      chk("rnd_order_err", 64'(order_err), 64'(m_err));
      if (pcq.size() != 0) chk("rnd_head_pc", 64'(head_pc), 64'(pcq[0]));
      $display("rnd %0d r1=%0b r2=%0b rv=%0b rid=%0d fl=%0b grant=%0b in_flight=%0d head=%0d err=%0b",
               n, r1, r2, rv, rid, fl, alloc_grant, in_flight, head_id, order_err);
      clock_it();
    end

    // Asynchronous reset in the middle of a cycle drops all in-flight tags at once.
    drive(0, 0, 0, 0, 0, 0, 1); clock_it();
    drive(1, 0, 'h900, 0, 0, 0, 0); clock_it();
    drive(0, 0, 0, 0, 1, 1, 0); clock_it();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("arst_pre_in_flight", 64'(in_flight), 1);
    chk("arst_pre_err", 64'(order_err), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_in_flight", 64'(in_flight), 0);
    chk("arst_head_valid", 64'(head_valid), 0);
    chk("arst_order_err", 64'(order_err), 0);
    chk("arst_two_free", 64'(two_free), 1);
    $display("arst in_flight=%0d order_err=%0b", in_flight, order_err);
    pcq.delete();
    m_head = 0;
    m_err  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_tag_allocator.md
Name: branch_tag_allocator

Overview:
- Controller for the in-flight branch checkpoint resource used by the decode stage.
- Hands out RAT checkpoint tags to branches leaving decode: up to two per cycle, for two compressed branches in one fetch word.
- Releases tags in program order as the predictor update port resolves branches, and clears everything on a flush.
- Produces the decode-side branch stall, occupancy flags and the head branch's PC and tag for the flush controller.

Parameters:
- PC_BITS, 32, width of the stored branch PC.
- MAX_BRANCH_IF, 2, number of checkpoint tags. Must be a power of two, ≥2.
- ID_BITS, $clog2(MAX_BRANCH_IF), tag width. Derived; do not override.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- alloc_req_1  in  1  one branch requests a tag this cycle.
- alloc_req_2  in  1  second branch in the same word requests a tag. Legal only with alloc_req_1.
- alloc_pc_1  in  PC_BITS  PC of branch 1.
- alloc_pc_2  in  PC_BITS  PC of branch 2.
- alloc_grant  out  1  request(s) accepted this cycle. Combinational.
- alloc_id_1  out  ID_BITS  tag for branch 1 (= tail). Combinational.
- alloc_id_2  out  ID_BITS  tag for branch 2 (= tail+1 mod MAX). Combinational.
- branch_stall  out  1  insufficient free tags for the current request. Combinational.
- resolve_valid  in  1  oldest branch resolved (pr_update.valid_jump).
- resolve_id  in  ID_BITS  tag being resolved.
- flush  in  1  clear all tags (must_flush).
- head_valid  out  1  at least one tag in flight.
- head_id  out  ID_BITS  oldest tag.
- head_pc  out  PC_BITS  PC stored for the oldest tag.
- in_flight  out  ID_BITS+1  registered occupancy count.
- one_free  out  1  in_flight < MAX_BRANCH_IF.
- two_free  out  1  in_flight ≤ MAX_BRANCH_IF-2.
- order_err  out  1  sticky protocol error flag.

Behaviour:
- **State:** head, tail (ID_BITS each); count (ID_BITS+1); pc_mem[MAX_BRANCH_IF]; order_err.
- **Reset:** head=0, tail=0, count=0, order_err=0. pc_mem is not reset.
- **Outputs after reset:** head_valid=0, head_id=0, in_flight=0, one_free=1, two_free=1, branch_stall=0, alloc_grant=0. head_pc is don't-care while head_valid=0.
- **Stall (registered count only; a tag freed this cycle is not reusable until the next cycle):**
  - branch_stall = (alloc_req_1 & ~alloc_req_2 & ~one_free) | (alloc_req_1 & alloc_req_2 & ~two_free).
- **Grant:** alloc_grant = alloc_req_1 & ~branch_stall & ~flush. A grant is all-or-nothing; two requests never get a partial grant.
- **Allocation on grant:**
  - pc_mem[tail] <= alloc_pc_1.
  - If alloc_req_2: pc_mem[tail+1] <= alloc_pc_2.
  - tail advances by 1 or 2, modulo MAX_BRANCH_IF (natural ID_BITS wrap).
- **Resolve:** accepted when resolve_valid & count≠0 & resolve_id==head & ~flush. On accept, head <= head+1 (wrap).
- **Resolve errors:**
  - resolve_valid with count==0 sets order_err. head and count unchanged.
  - resolve_id≠head with count≠0 sets order_err. The resolve is ignored.
  - order_err clears only on reset or flush.
- **Count:** count <= count + granted_n − resolved, where granted_n is 0, 1 or 2 and resolved is 0 or 1.
  - Simultaneous grant and resolve are both applied in the same cycle.
  - Count never exceeds MAX_BRANCH_IF; this is guaranteed by the stall.
- **Flush (highest priority):**
  - head <= 0, tail <= 0, count <= 0, order_err <= 0.
  - Requests and resolves in the same cycle are dropped and alloc_grant is 0.
  - branch_stall itself does not depend on flush.
- **Derived outputs:** head_valid = count≠0. one_free and two_free are decoded from the registered count. in_flight = count.
- **Latency:** grants and tag IDs are same-cycle. Occupancy and head updates are visible the next cycle.
- **Timing:** no combinational path from resolve_valid to branch_stall or alloc_grant.
- **Asynchronous reset mid-operation:** all in-flight tags are lost and the block returns to the reset state immediately.

Test Plan:
- **Single allocate/resolve:** reset; req_1 with pc=0x100 → grant=1, id_1=0. Next cycle in_flight=1, head_pc=0x100. Resolve id 0 → in_flight=0, head_id=1.
- **Dual allocate then full:** MAX=2; req_1+req_2 with pcs 0x200/0x202 → ids 0/1, grant=1. Next cycle in_flight=2, one_free=0. A further req_1 → branch_stall=1, grant=0.
- **Resolve and allocate in the same cycle while full:** in_flight=2; resolve id 0 with req_1 → stall=1 (registered count). Next cycle in_flight=1, req_1 → grant, id_1=0 (wrap), in_flight=2.
- **Dual request with one tag free:** in_flight=1; req_1+req_2 → stall=1, no partial grant, tail unchanged.
- **Flush priority:** in_flight=2; flush with req_1 and resolve both asserted → next cycle in_flight=0, head=tail=0, no grant.
- **Protocol errors:** resolve when empty → order_err=1, count stays 0. Flush → order_err=0. With head=1, resolve id 0 → order_err=1, head stays 1.
